// File: rtl/dram_bist_engine.sv
// DRAM built-in self-test: write-then-read-back sweep over a block region with patterns, error count and watchdog.
// Optional first-failure data capture is enabled by defining DRAM_BIST_ERR_CAPTURE_EN.
module dram_bist_engine #(
    parameter int unsigned ADDR_BITS      = 27,
    parameter int unsigned BLOCK_BITS     = 512,
    parameter int unsigned COUNT_BITS     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_BITS-1:0]  start_addr,
    input  logic [COUNT_BITS-1:0] block_count,
    input  logic [31:0]           seed,
    input  logic                  write_ready,
    output logic                  write_request,
    output logic [ADDR_BITS-1:0]  write_address,
    output logic [BLOCK_BITS-1:0] write_data,
    input  logic                  read_ready,
    output logic                  read_request,
    output logic [ADDR_BITS-1:0]  read_address,
    input  logic                  read_response,
    input  logic [BLOCK_BITS-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [COUNT_BITS-1:0] error_count,
    output logic [ADDR_BITS-1:0]  first_err_addr
`ifdef DRAM_BIST_ERR_CAPTURE_EN
    ,
    output logic [BLOCK_BITS-1:0] first_err_expected,
    output logic [BLOCK_BITS-1:0] first_err_actual
`else
`endif
);

    localparam int unsigned LANES   = BLOCK_BITS / 32;
    localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE, W_REQ, W_ACK, W_DONE, R_REQ, R_WAIT, NEXT, FIN
    } state_t;

    state_t                  state_q;
    logic [1:0]              mode_q;
    logic [ADDR_BITS-1:0]    base_q;
    logic [COUNT_BITS-1:0]   last_q;
    logic [COUNT_BITS-1:0]   idx_q;
    logic [31:0]             seed_q;
    logic [31:0]             lfsr_q;
    logic [WD_BITS-1:0]      wd_q;
    logic [BLOCK_BITS-1:0]   exp_q;
    logic                    wreq_q;
    logic [ADDR_BITS-1:0]    waddr_q;
    logic [BLOCK_BITS-1:0]   wdata_q;
    logic                    rreq_q;
    logic [ADDR_BITS-1:0]    raddr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic                    timeout_q;
    logic [COUNT_BITS-1:0]   err_q;
    logic [ADDR_BITS-1:0]    ferr_q;
`ifdef DRAM_BIST_ERR_CAPTURE_EN
    logic [BLOCK_BITS-1:0]   fexp_q;
    logic [BLOCK_BITS-1:0]   fact_q;
`endif

    logic [ADDR_BITS-1:0]    addr_d;
    logic [BLOCK_BITS-1:0]   pat_d;
    logic [31:0]             lfsr_d;
    logic                    counted;
    logic                    progress;
    logic                    wd_expired;

    function automatic logic [BLOCK_BITS-1:0] pattern(
        input logic [1:0]            m,
        input logic [ADDR_BITS-1:0]  a,
        input logic [COUNT_BITS-1:0] i,
        input logic [31:0]           l
    );
        logic [BLOCK_BITS-1:0] p;
        logic [31:0]           ik;
        logic [63:0]           rot;
        p = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            ik  = 32'(i) + k;
            rot = {l, l} << k[4:0];
            case (m)
                2'd0:    p[k*32 +: 32] = 32'(a) + k;
                2'd1:    p[k*32 +: 32] = 32'd1 << ik[4:0];
                2'd2:    p[k*32 +: 32] = rot[63:32];
                default: p[k*32 +: 32] = ik[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            endcase
        end
        return p;
    endfunction

    always_comb begin
        addr_d     = base_q + ADDR_BITS'(idx_q);
        pat_d      = pattern(mode_q, addr_d, idx_q, lfsr_q);
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        wd_expired = (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1));
        counted    = 1'b1;
        progress   = 1'b1;
        case (state_q)
            W_REQ:   progress = write_ready;
            W_ACK:   progress = !write_ready;
            W_DONE:  progress = write_ready;
            R_REQ:   progress = read_ready;
            R_WAIT:  progress = read_response;
            default: counted  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            base_q    <= '0;
            last_q    <= '0;
            idx_q     <= '0;
            seed_q    <= 32'h1;
            lfsr_q    <= 32'h1;
            wd_q      <= '0;
            exp_q     <= '0;
            wreq_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rreq_q    <= 1'b0;
            raddr_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            ferr_q    <= '0;
`ifdef DRAM_BIST_ERR_CAPTURE_EN
            fexp_q    <= '0;
            fact_q    <= '0;
`endif
        end else begin
            wreq_q <= 1'b0;
            rreq_q <= 1'b0;
            // Watchdog fires only while stalled; any state exit restarts it at zero.
            if (counted && !progress && wd_expired) begin
                timeout_q <= 1'b1;
                wd_q      <= '0;
                state_q   <= FIN;
            end else begin
                wd_q <= counted ? wd_q + 1'b1 : '0;
                case (state_q)
                    IDLE: if (start) begin
                        mode_q    <= mode;
                        base_q    <= start_addr;
                        last_q    <= (block_count == '0) ? '0 : block_count - 1'b1;
                        seed_q    <= (seed == 32'h0) ? 32'h1 : seed;
                        lfsr_q    <= (seed == 32'h0) ? 32'h1 : seed;
                        idx_q     <= '0;
                        err_q     <= '0;
                        ferr_q    <= '0;
                        timeout_q <= 1'b0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef DRAM_BIST_ERR_CAPTURE_EN
                        fexp_q    <= '0;
                        fact_q    <= '0;
`endif
                        state_q   <= W_REQ;
                    end
                    W_REQ: if (write_ready) begin
                        wreq_q  <= 1'b1;
                        waddr_q <= addr_d;
                        wdata_q <= pat_d;
                        lfsr_q  <= lfsr_d;
                        wd_q    <= '0;
                        state_q <= W_ACK;
                    end
                    W_ACK: if (!write_ready) begin
                        wd_q    <= '0;
                        state_q <= W_DONE;
                    end
                    W_DONE: if (write_ready) begin
                        wd_q <= '0;
                        if (idx_q == last_q) begin
                            idx_q   <= '0;
                            lfsr_q  <= seed_q;
                            state_q <= R_REQ;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= W_REQ;
                        end
                    end
                    R_REQ: if (read_ready) begin
                        rreq_q  <= 1'b1;
                        raddr_q <= addr_d;
                        exp_q   <= pat_d;
                        lfsr_q  <= lfsr_d;
                        wd_q    <= '0;
                        state_q <= R_WAIT;
                    end
                    R_WAIT: if (read_response) begin
                        wd_q <= '0;
                        if (read_data != exp_q) begin
                            if (err_q != '1) err_q <= err_q + 1'b1;
                            if (err_q == '0) begin
                                ferr_q <= raddr_q;
`ifdef DRAM_BIST_ERR_CAPTURE_EN
                                fexp_q <= exp_q;
                                fact_q <= read_data;
`endif
                            end
                        end
                        state_q <= NEXT;
                    end
                    NEXT: begin
                        if (idx_q == last_q) begin
                            state_q <= FIN;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= R_REQ;
                        end
                    end
                    FIN: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !timeout_q;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign write_request  = wreq_q;
    assign write_address  = waddr_q;
    assign write_data     = wdata_q;
    assign read_request   = rreq_q;
    assign read_address   = raddr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign error_count    = err_q;
    assign first_err_addr = ferr_q;
`ifdef DRAM_BIST_ERR_CAPTURE_EN
    assign first_err_expected = fexp_q;
    assign first_err_actual   = fact_q;
`endif

endmodule

// File: tb/tb_dram_bist_engine.sv
// Self-checking bench for dram_bist_engine: table of directed sweeps plus timeout and mid-test reset sequences.
module tb_dram_bist_engine;

    localparam int unsigned AB = 27;
    localparam int unsigned BB = 512;
    localparam int unsigned CB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [AB-1:0] start_addr = '0;
    logic [CB-1:0] block_count = '0;
    logic [31:0]   seed = '0;
    logic          write_ready = 1'b1;
    logic          write_request;
    logic [AB-1:0] write_address;
    logic [BB-1:0] write_data;
    logic          read_ready = 1'b1;
    logic          read_request;
    logic [AB-1:0] read_address;
    logic          read_response = 1'b0;
    logic [BB-1:0] read_data = '0;
    logic          busy, done, pass, timeout;
    logic [CB-1:0] error_count;
    logic [AB-1:0] first_err_addr;
`ifdef DRAM_BIST_ERR_CAPTURE_EN
    logic [BB-1:0] first_err_expected, first_err_actual;
`endif

    dram_bist_engine #(.ADDR_BITS(AB), .BLOCK_BITS(BB), .COUNT_BITS(CB), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .start_addr(start_addr),
        .block_count(block_count), .seed(seed),
        .write_ready(write_ready), .write_request(write_request),
        .write_address(write_address), .write_data(write_data),
        .read_ready(read_ready), .read_request(read_request), .read_address(read_address),
        .read_response(read_response), .read_data(read_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .error_count(error_count), .first_err_addr(first_err_addr)
`ifdef DRAM_BIST_ERR_CAPTURE_EN
        , .first_err_expected(first_err_expected), .first_err_actual(first_err_actual)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: write_ready low 3 cycles per write, response 10 cycles after read request.
    logic [BB-1:0] mem [logic [AB-1:0]];
    logic [AB-1:0] wlog_a[$];
    logic [BB-1:0] wlog_d[$];
    logic [AB-1:0] rlog_a[$];
    int unsigned   wcnt = 0, rcnt = 0;
    logic [AB-1:0] rpend = '0;
    bit            fault_en = 1'b0;
    bit            resp_en = 1'b1;
    logic [AB-1:0] fault_addr = '0;

    always @(negedge clk) begin
        read_response = 1'b0;
        if (write_request) begin
            wlog_a.push_back(write_address);
            wlog_d.push_back(write_data);
            mem[write_address] = write_data;
            wcnt = 3;
            write_ready = 1'b0;
        end else if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) write_ready = 1'b1;
        end
        if (read_request) begin
            rlog_a.push_back(read_address);
            if (resp_en) begin
                rcnt = 10;
                rpend = read_address;
                read_ready = 1'b0;
            end
        end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                read_data = mem.exists(rpend) ? mem[rpend] : '0;
                if (fault_en && rpend == fault_addr) read_data[7] = ~read_data[7];
                read_response = 1'b1;
                read_ready = 1'b1;
            end
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int unsigned lim, output int unsigned cyc);
        cyc = 0;
        while (!done && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL wait_done: done=0 after %0d cycles, required 1", cyc);
        end
    endtask

    function automatic logic [31:0] galois(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    function automatic logic [BB-1:0] exp_pat(input logic [1:0] m, input logic [AB-1:0] a,
                                              input int unsigned i, input logic [31:0] l);
        logic [BB-1:0] p;
        logic [31:0]   lane;
        for (int unsigned k = 0; k < BB / 32; k++) begin
            case (m)
                2'd0: lane = {5'b0, a} + k;
                2'd1: lane = 32'h1 << ((i + k) % 32);
                2'd2: lane = (k % 32 == 0) ? l : ((l << (k % 32)) | (l >> (32 - (k % 32))));
                default: lane = ((i + k) % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            endcase
            p[k*32 +: 32] = lane;
        end
        return p;
    endfunction

    typedef struct {
        logic [1:0]    mode;
        logic [AB-1:0] sa;
        logic [CB-1:0] cnt;
        logic [31:0]   seed;
        bit            flip;
        logic [AB-1:0] faddr;
        logic [CB-1:0] exp_err;
        logic [AB-1:0] exp_first;
        bit            exp_pass;
        int unsigned   blocks;
    } vec_t;

    vec_t vecs[7];

    task automatic pulse_start(input logic [1:0] m, input logic [AB-1:0] sa,
                               input logic [CB-1:0] c, input logic [31:0] s);
        mode = m; start_addr = sa; block_count = c; seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int unsigned   cyc, wb, rb, nw, nreq;
        logic [AB-1:0] a;
        logic [31:0]   l;

        vecs[0] = '{2'd0, 27'h100,     16'd4, 32'h0,        1'b0, 27'h0,   16'd0, 27'h0,   1'b1, 4};
        vecs[1] = '{2'd0, 27'h100,     16'd4, 32'h0,        1'b1, 27'h102, 16'd1, 27'h102, 1'b0, 4};
        vecs[2] = '{2'd2, 27'h200,     16'd3, 32'h0,        1'b0, 27'h0,   16'd0, 27'h0,   1'b1, 3};
        vecs[3] = '{2'd3, 27'h7FFFFFE, 16'd4, 32'h0,        1'b0, 27'h0,   16'd0, 27'h0,   1'b1, 4};
        vecs[4] = '{2'd1, 27'h10,      16'd0, 32'h0,        1'b0, 27'h0,   16'd0, 27'h0,   1'b1, 1};
        vecs[5] = '{2'd1, 27'h20,      16'd2, 32'h0,        1'b1, 27'h21,  16'd1, 27'h21,  1'b0, 2};
        vecs[6] = '{2'd2, 27'h500,     16'd2, 32'hDEADBEEF, 1'b1, 27'h500, 16'd1, 27'h500, 1'b0, 2};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_errcnt", error_count, 0);
        chk("rst_first", first_err_addr, 0);
        chk("rst_reqs", {write_request, read_request}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            fault_en = vecs[v].flip; fault_addr = vecs[v].faddr; resp_en = 1'b1;
            wb = wlog_a.size(); rb = rlog_a.size();
            pulse_start(vecs[v].mode, vecs[v].sa, vecs[v].cnt, vecs[v].seed);
            chk("busy_after_start", busy, 1);
            chk("done_cleared", done, 0);
            wait_done(2000, cyc);
            chk("busy_at_done", busy, 0);
            chk("pass", pass, vecs[v].exp_pass);
            chk("timeout", timeout, 0);
            chk("error_count", error_count, vecs[v].exp_err);
            chk("first_err_addr", first_err_addr, vecs[v].exp_first);
            chk("n_writes", wlog_a.size() - wb, vecs[v].blocks);
            chk("n_reads", rlog_a.size() - rb, vecs[v].blocks);
            l = (vecs[v].seed == 32'h0) ? 32'h1 : vecs[v].seed;
            for (int unsigned j = 0; j < vecs[v].blocks; j++) begin
                a = vecs[v].sa + AB'(j);
                if (wb + j < wlog_a.size()) begin
                    chk("write_addr", wlog_a[wb+j], a);
                    chkw("write_data", wlog_d[wb+j], exp_pat(vecs[v].mode, a, j, l));
                end
                if (rb + j < rlog_a.size()) chk("read_addr", rlog_a[rb+j], a);
                l = galois(l);
            end
`ifdef DRAM_BIST_ERR_CAPTURE_EN
            if (vecs[v].exp_err != 0)
                chkw("capture_xor", first_err_expected ^ first_err_actual, {{(BB-8){1'b0}}, 8'h80});
`endif
            repeat (4) @(negedge clk);
            chk("done_held", done, 1);
        end

        // Read response never arrives: watchdog must end the test.
        fault_en = 1'b0; resp_en = 1'b0;
        pulse_start(2'd0, 27'h300, 16'd1, 32'h0);
        cyc = 0;
        while (!read_request && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_read_issued", read_request, 1);
        wait_done(6000, cyc);
        n_cmp++;
        if (cyc < 4095 || cyc > 4099) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles expected about 4097", cyc);
        end
        chk("to_timeout", timeout, 1);
        chk("to_pass", pass, 0);
        chk("to_busy", busy, 0);
        resp_en = 1'b1;
        repeat (20) @(negedge clk);

        // Reset while the third block's write is being acknowledged.
        pulse_start(2'd0, 27'h400, 16'd4, 32'h0);
        nw = 0; cyc = 0;
        while (nw < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (write_request) nw++;
        end
        chk("rst_mid_reached", nw, 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        nreq = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (write_request || read_request) nreq++;
        end
        chk("rst_mid_no_reqs", nreq, 0);

        wb = wlog_a.size();
        pulse_start(2'd3, 27'h400, 16'd4, 32'h0);
        repeat (5) @(negedge clk);
        pulse_start(2'd0, 27'h900, 16'd10, 32'h0);
        wait_done(2000, cyc);
        chk("rerun_pass", pass, 1);
        chk("rerun_writes", wlog_a.size() - wb, 4);
        if (wb < wlog_a.size()) chk("rerun_first_addr", wlog_a[wb], 27'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dram_bist_engine.md
Name: dram_bist_engine

Overview:
- Autonomous DRAM built-in self-test engine on the sys_clk side of the dram CDC boundary.
- Generalises the button-driven single-block read/write test into a programmable write-then-read-back sweep over a region of cache blocks.
- Supports selectable data patterns, per-block compare, error counting, first-fail capture and a handshake watchdog.
- Drives the same request/ready/response interface that the dram wrapper exposes through cdc_pipe/cdc_pulse.

Parameters:
- ADDR_BITS, 27, width of the DRAM block address.
- BLOCK_BITS, 512, data bits per cache block; must be a multiple of 32.
- COUNT_BITS, 16, width of block_count and error_count.
- TIMEOUT_CYCLES, 4096, maximum cycles in any wait state before abort.

Ports:
- clk  in  1  system clock (sys_clk domain).
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; starts a test when idle.
- mode  in  2  pattern: 0 ADDR, 1 WALK, 2 LFSR, 3 CHECKER.
- start_addr  in  ADDR_BITS  first block address.
- block_count  in  COUNT_BITS  number of blocks; 0 is treated as 1.
- seed  in  32  LFSR seed; 0 is replaced by 32'h1.
- write_ready  in  1  DRAM write path idle.
- write_request  out  1  single-cycle write pulse.
- write_address  out  ADDR_BITS  write address.
- write_data  out  BLOCK_BITS  write data.
- read_ready  in  1  DRAM read path idle.
- read_request  out  1  single-cycle read pulse.
- read_address  out  ADDR_BITS  read address.
- read_response  in  1  read_data valid this cycle.
- read_data  in  BLOCK_BITS  returned block.
- busy  out  1  test in progress.
- done  out  1  high from test end until next start or rst.
- pass  out  1  valid when done: error_count==0 and no timeout.
- timeout  out  1  a wait state expired.
- error_count  out  COUNT_BITS  mismatching blocks; saturates at all-ones.
- first_err_addr  out  ADDR_BITS  address of first mismatch.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, LFSR = 1.
- States: IDLE, W_REQ, W_ACK, W_DONE, R_REQ, R_WAIT, NEXT, FIN.
- IDLE: on start, latch mode, start_addr, block_count and seed; clear error_count, first_err_addr, timeout and done; set busy; index i=0; LFSR=seed; go to W_REQ. start is ignored while busy.
- W_REQ: when write_ready=1, assert write_request for one cycle with address = start_addr+i (modulo 2^ADDR_BITS) and write_data = pattern(i); go to W_ACK. write_address/write_data are held stable from the request until W_DONE exits.
- W_ACK: wait for write_ready=0 (accepted), then go to W_DONE.
- W_DONE: wait for write_ready=1. Then i++; at the last block, reset i=0, reload LFSR=seed and go to R_REQ; otherwise go to W_REQ.
- R_REQ: when read_ready=1, pulse read_request with read_address = start_addr+i; go to R_WAIT.
- R_WAIT: on read_response, compare read_data against pattern(i). On mismatch, error_count++ (saturating), and if this is the first error, first_err_addr = address. Go to NEXT.
- NEXT: i++. At the last block go to FIN, otherwise go to R_REQ.
- FIN: busy=0, done=1, pass = (error_count==0 && !timeout); go to IDLE.
- Watchdog: the counter clears on every state entry and counts in W_REQ, W_ACK, W_DONE, R_REQ and R_WAIT. Reaching TIMEOUT_CYCLES sets timeout=1 and jumps to FIN.
- A read_response outside R_WAIT is ignored.
- Patterns: 32-bit lane k, 0 ≤ k < BLOCK_BITS/32, with addr = start_addr+i.
  - ADDR: lane = zero-extended addr + k.
  - WALK: lane = 1 << ((i+k) mod 32).
  - LFSR: lane = LFSR rotated left by k. The Galois LFSR (taps 0x80200003) advances once per block after use.
  - CHECKER: lane = 0x55555555 if (i+k) is even, else 0xAAAAAAAA.
- Timing: pattern(i) is registered; compare result is available in the cycle after read_response. No combinational path from inputs to request outputs.
- Reset mid-test: FSM returns to IDLE immediately, with no further requests issued.

Optional Feature:
- Macro: DRAM_BIST_ERR_CAPTURE_EN.
- Defined: adds outputs first_err_expected and first_err_actual, each BLOCK_BITS wide, captured with first_err_addr and cleared on start/rst.
- Undefined: these ports and their registers do not exist.

Test Plan:
- Ideal memory model (ready toggles low for 3 cycles, response 10 cycles after request), mode 0, start_addr=0x100, count=4 -> 4 writes to 0x100–0x103, then 4 reads; done=1, pass=1, error_count=0.
- Same setup, but the model flips bit 7 of the block at 0x102 -> error_count=1, first_err_addr=0x102, pass=0; with the feature defined, expected^actual = 1<<7.
- mode 2, seed=0, count=3 -> LFSR starts at 1; read pass regenerates identical data; pass=1.
- Model never returns read_response -> timeout=1 after 4096 cycles in R_WAIT; done=1, pass=0.
- start_addr = 2^27−2, count=4, mode 3 -> addresses 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1; pass=1.
- rst asserted during W_ACK of block 2 -> busy=0, done=0, no requests after reset; a subsequent start runs a full test cleanly.
